uart_frame_monitor: RTL and testbench

- Synthesizable serial-line consumer placed directly downstream of the UART tx pin.
- Decodes frames with the same programmable format as the UART core: 5–9 data bits, parity modes, 1/2 stop bits.
- Reports each received word, parity/framing/break errors and a running frame count.
- Used in benches as a scoreboard front end; usable in silicon as a loopback checker.

---
 rtl/uart_frame_monitor_if.sv | 44 ++++
 rtl/uart_frame_monitor.sv | 230 +++++++++++++++++++++++
 tb/tb_uart_frame_monitor.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_monitor_if.sv
`default_nettype none
// ============================================================================
// Module  : uart_frame_monitor_if
// Purpose : Groups the format controls, serial line and frame report of the
//           UART frame monitor into one bundle.
// Modports: master - drives en/line/format, observes the report (bench/host)
//           slave  - the monitor itself
// Signals : en, line, prescaler, data_size, parity_type, two_stop (to monitor)
//           frame_valid, frame_data, parity_err, frame_err, break_det, busy,
//           frame_cnt, err_cnt (from monitor)
// Revision: 1.0 - initial release
// ============================================================================
interface uart_frame_monitor_if #(
  parameter int PRESCALE_W = 16,
  parameter int CNT_W      = 16
);
  logic                  en;
  logic                  line;
  logic [PRESCALE_W-1:0] prescaler;
  logic [3:0]            data_size;
  logic [2:0]            parity_type;
  logic                  two_stop;
  logic                  frame_valid;
  logic [8:0]            frame_data;
  logic                  parity_err;
  logic                  frame_err;
  logic                  break_det;
  logic                  busy;
  logic [CNT_W-1:0]      frame_cnt;
  logic [CNT_W-1:0]      err_cnt;

  modport master (
    output en, line, prescaler, data_size, parity_type, two_stop,
    input  frame_valid, frame_data, parity_err, frame_err, break_det, busy,
           frame_cnt, err_cnt
  );

  modport slave (
    input  en, line, prescaler, data_size, parity_type, two_stop,
    output frame_valid, frame_data, parity_err, frame_err, break_det, busy,
           frame_cnt, err_cnt
  );
endinterface
`default_nettype wire

// File: rtl/uart_frame_monitor.sv
`default_nettype none
// ============================================================================
// Module  : uart_frame_monitor
// Purpose : Serial-line frame decoder for a UART tx pin. Decodes 5..9 data
//           bits, none/odd/even/stick parity and 1 or 2 stop bits, reports
//           each word with parity/framing/break flags and keeps frame and
//           error counters.
// Ports   : clk    - block clock
//           rst_n  - asynchronous active-low reset
//           bus    - uart_frame_monitor_if.slave (line, format, report)
// Option  : UART_MON_GLITCH_FILTER_EN - 2-of-3 majority of samples 6/7/8
//           per bit instead of a single sample at 7.
// Revision: 1.0 - initial release
// ============================================================================
module uart_frame_monitor #(
  parameter int PRESCALE_W = 16,
  parameter int CNT_W      = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  uart_frame_monitor_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_BRK_WAIT
  } state_t;

  state_t                r_state, w_next;
  logic                  r_sync1, r_sync2, r_sync3;
  logic [PRESCALE_W-1:0] r_tick_cnt, r_prescale;
  logic [3:0]            r_samp_cnt, r_bit_idx, r_nbits;
  logic [2:0]            r_par_mode;
  logic                  r_two_stop;
  logic [8:0]            r_shift;
  logic                  r_any_one, r_perr, r_ferr;
  logic                  r_frame_valid, r_parity_err, r_frame_err, r_break_det;
  logic [8:0]            r_frame_data;
  logic [CNT_W-1:0]      r_frame_cnt, r_err_cnt;

  logic w_tick, w_bit, w_samp, w_bitend, w_start, w_brk, w_report;
  logic w_stop_err, w_has_par, w_par_exp;
  logic [3:0] w_nbits_in;
  logic [2:0] w_par_in;

  // Line synchronizer; r_sync3 is the previous synchronized value for edge
  // detection. Presetting to 1 keeps reset from looking like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_sync3 <= 1'b1;
    end else begin
      r_sync1 <= bus.line;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign w_tick = (r_tick_cnt == '0);

`ifdef UART_MON_GLITCH_FILTER_EN
  localparam logic [3:0] c_samp_pt = 4'd8;
  logic r_s6, r_s7;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s6 <= 1'b1;
      r_s7 <= 1'b1;
    end else if (w_tick && (r_state != S_IDLE)) begin
      if (r_samp_cnt == 4'd6) r_s6 <= r_sync2;
      if (r_samp_cnt == 4'd7) r_s7 <= r_sync2;
    end
  end

  // Decision taken at count 8 using the live sample as the third vote.
  assign w_bit = (r_s6 & r_s7) | (r_s6 & r_sync2) | (r_s7 & r_sync2);
`else
  localparam logic [3:0] c_samp_pt = 4'd7;
  assign w_bit = r_sync2;
`endif

  assign w_samp   = (r_state != S_IDLE) && w_tick && (r_samp_cnt == c_samp_pt);
  assign w_bitend = (r_state != S_IDLE) && w_tick && (r_samp_cnt == 4'd15);
  assign w_start  = bus.en && r_sync3 && !r_sync2;
  assign w_has_par = (r_par_mode != 3'b000);
  // Break: nothing but zeros up to and including the first stop sample.
  assign w_brk    = (r_state == S_STOP1) && !w_bit && !r_any_one;
  assign w_report = bus.en && w_samp &&
                    (((r_state == S_STOP1) && (w_brk || !r_two_stop)) ||
                     (r_state == S_STOP2));
  assign w_stop_err = !w_bit || ((r_state == S_STOP2) && r_ferr);

  // Illegal format codes fold to 8 data bits / no parity at latch time.
  assign w_nbits_in = ((bus.data_size >= 4'd5) && (bus.data_size <= 4'd9)) ?
                      bus.data_size : 4'd8;
  always_comb begin
    w_par_in = 3'b000;
    case (bus.parity_type)
      3'b001, 3'b010, 3'b100, 3'b101: w_par_in = bus.parity_type;
      default:                        w_par_in = 3'b000;
    endcase
  end

  // Unreceived bits of r_shift are 0, so reduction XOR covers exactly the word.
  always_comb begin
    w_par_exp = 1'b0;
    case (r_par_mode)
      3'b001:  w_par_exp = ~^r_shift;
      3'b010:  w_par_exp = ^r_shift;
      3'b101:  w_par_exp = 1'b1;
      default: w_par_exp = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (w_start) w_next = S_START;
      S_START: begin
        if (w_samp && w_bit) w_next = S_IDLE;
        else if (w_bitend)   w_next = S_DATA;
      end
      S_DATA: begin
        if (w_bitend && (r_bit_idx == r_nbits))
          w_next = w_has_par ? S_PARITY : S_STOP1;
      end
      S_PARITY:   if (w_bitend) w_next = S_STOP1;
      S_STOP1: begin
        if (w_samp) begin
          if (w_brk)            w_next = S_BRK_WAIT;
          else if (!r_two_stop) w_next = S_IDLE;
        end else if (w_bitend) begin
          w_next = S_STOP2;
        end
      end
      S_STOP2:    if (w_samp) w_next = S_IDLE;
      S_BRK_WAIT: if (r_sync2) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
    if (!bus.en) w_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_cnt    <= '0;
      r_prescale    <= '0;
      r_samp_cnt    <= '0;
      r_bit_idx     <= '0;
      r_nbits       <= 4'd8;
      r_par_mode    <= '0;
      r_two_stop    <= 1'b0;
      r_shift       <= '0;
      r_any_one     <= 1'b0;
      r_perr        <= 1'b0;
      r_ferr        <= 1'b0;
      r_frame_valid <= 1'b0;
      r_frame_data  <= '0;
      r_parity_err  <= 1'b0;
      r_frame_err   <= 1'b0;
      r_break_det   <= 1'b0;
      r_frame_cnt   <= '0;
      r_err_cnt     <= '0;
    end else begin
      r_frame_valid <= 1'b0;
      if (r_state == S_IDLE) begin
        r_tick_cnt <= bus.prescaler;
        r_samp_cnt <= '0;
        if (w_start) begin
          r_prescale <= bus.prescaler;
          r_nbits    <= w_nbits_in;
          r_par_mode <= w_par_in;
          r_two_stop <= bus.two_stop;
          r_shift    <= '0;
          r_bit_idx  <= '0;
          r_any_one  <= 1'b0;
          r_perr     <= 1'b0;
          r_ferr     <= 1'b0;
        end
      end else begin
        if (w_tick) begin
          r_tick_cnt <= r_prescale;
          r_samp_cnt <= r_samp_cnt + 4'd1;
        end else begin
          r_tick_cnt <= r_tick_cnt - PRESCALE_W'(1);
        end
        if (w_samp) begin
          case (r_state)
            S_DATA: begin
              r_shift[r_bit_idx] <= w_bit;
              r_bit_idx          <= r_bit_idx + 4'd1;
              r_any_one          <= r_any_one | w_bit;
            end
            S_PARITY: begin
              r_perr    <= (w_bit != w_par_exp);
              r_any_one <= r_any_one | w_bit;
            end
            S_STOP1: r_ferr <= !w_bit;
            default: ;
          endcase
        end
      end
      if (w_report) begin
        r_frame_valid <= 1'b1;
        r_frame_data  <= r_shift;
        r_parity_err  <= r_perr;
        r_frame_err   <= w_stop_err;
        r_break_det   <= w_brk;
        r_frame_cnt   <= r_frame_cnt + CNT_W'(1);
        if (r_perr || w_stop_err || w_brk)
          r_err_cnt <= r_err_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.frame_valid = r_frame_valid;
  assign bus.frame_data  = r_frame_data;
  assign bus.parity_err  = r_parity_err;
  assign bus.frame_err   = r_frame_err;
  assign bus.break_det   = r_break_det;
  assign bus.busy        = (r_state != S_IDLE) && bus.en;
  assign bus.frame_cnt   = r_frame_cnt;
  assign bus.err_cnt     = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_monitor.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_frame_monitor
// Purpose : Self-checking bench for uart_frame_monitor. A serial transmitter
//           model drives the line and queues the expected report of each
//           frame; an independent monitor pops and compares on frame_valid.
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_frame_monitor;
  localparam int PW = 16;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  uart_frame_monitor_if #(.PRESCALE_W(PW), .CNT_W(CW)) bus ();
  uart_frame_monitor #(.PRESCALE_W(PW), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] data;
    bit         perr;
    bit         ferr;
    bit         brk;
    bit         chk_lat;
    longint     fall;
  } exp_t;

  exp_t   q[$];
  int     total = 0;
  int     bad   = 0;
  int     exp_f = 0;
  int     exp_e = 0;
  longint cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic chk_rng(input string name, input longint act,
                         input longint lo, input longint hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d..%0d", name, act, lo, hi);
    end
  endtask

  // Scoreboard monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.frame_valid) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_frame: actual data=%0h required no frame", bus.frame_data);
        end else begin
          e = q.pop_front();
          chk("frame_data", bus.frame_data, e.data);
          chk("parity_err", bus.parity_err, e.perr);
          chk("frame_err",  bus.frame_err,  e.ferr);
          chk("break_det",  bus.break_det,  e.brk);
          if (e.chk_lat) chk_rng("latency", cyc - e.fall, 154, 156);
          exp_f++;
          if (e.perr || e.ferr || e.brk) exp_e++;
          chk("frame_cnt", bus.frame_cnt, exp_f % 65536);
          chk("err_cnt",   bus.err_cnt,   exp_e % 65536);
        end
      end
    end
  end

  task automatic nclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic b, input int n);
    bus.line = b;
    nclk(n);
  endtask

  // Transmitter + reference model: expected report derived from the frame
  // format currently on the bus and the injected faults.
  task automatic send_frame(input logic [8:0] d, input bit flip, input bit bad_stop,
                            input bit scramble, input bit chk_lat);
    int         nb, bc;
    logic [2:0] pm;
    bit         has_par, two, pbit;
    logic [8:0] dm;
    exp_t       e;
    bc = (int'(bus.prescaler) + 1) * 16;
    nb = (bus.data_size >= 5 && bus.data_size <= 9) ? int'(bus.data_size) : 8;
    pm = bus.parity_type;
    two = bus.two_stop;
    has_par = (pm == 3'b001) || (pm == 3'b010) || (pm == 3'b100) || (pm == 3'b101);
    dm = '0;
    for (int i = 0; i < nb; i++) dm[i] = d[i];
    case (pm)
      3'b001:  pbit = ($countones(dm) % 2 == 0);
      3'b010:  pbit = ($countones(dm) % 2 == 1);
      3'b101:  pbit = 1'b1;
      default: pbit = 1'b0;
    endcase
    pbit = pbit ^ flip;
    e.data    = dm;
    e.perr    = has_par && flip;
    e.ferr    = bad_stop;
    e.brk     = (dm == 9'd0) && (!has_par || !pbit) && bad_stop;
    e.chk_lat = chk_lat;
    e.fall    = cyc;
    q.push_back(e);
    drive(1'b0, bc);
    if (scramble) begin
      bus.prescaler   = PW'($urandom_range(0, 3));
      bus.data_size   = 4'($urandom_range(0, 15));
      bus.parity_type = 3'($urandom_range(0, 7));
      bus.two_stop    = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < nb; i++) drive(dm[i], bc);
    if (has_par) drive(pbit, bc);
    drive(!bad_stop, bc);
    if (two) drive(1'b1, bc);
  endtask

  task automatic wait_drain(input int lim);
    int k = 0;
    while (q.size() != 0 && k < lim) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: actual pending=%0d required 0", q.size());
      q.delete();
    end
  endtask

  task automatic set_fmt(input int p, input int ds, input int pt, input bit two);
    bus.prescaler   = PW'(p);
    bus.data_size   = 4'(ds);
    bus.parity_type = 3'(pt);
    bus.two_stop    = two;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_f = 0;
    exp_e = 0;
    nclk(3);
    chk("rst_busy",        bus.busy, 0);
    chk("rst_frame_valid", bus.frame_valid, 0);
    chk("rst_frame_data",  bus.frame_data, 0);
    chk("rst_flags",       {bus.parity_err, bus.frame_err, bus.break_det}, 0);
    chk("rst_frame_cnt",   bus.frame_cnt, 0);
    chk("rst_err_cnt",     bus.err_cnt, 0);
    rst_n = 1'b1;
    nclk(5);
  endtask

  initial begin
    logic [8:0] d;
    exp_t       e;
    @(negedge clk);
    bus.en = 1'b1;
    bus.line = 1'b1;
    set_fmt(0, 8, 0, 0);
    do_reset();

    // 8N1, prescaler 0, 0xA5 with latency check
    send_frame(9'h0A5, 0, 0, 0, 1);
    drive(1'b1, 32);
    wait_drain(200);
    chk("t1_frame_cnt", bus.frame_cnt, 1);

    // 7E2, prescaler 3: good parity then flipped parity
    set_fmt(3, 7, 2, 1);
    drive(1'b1, 64);
    send_frame(9'h055, 0, 0, 0, 0);
    drive(1'b1, 64);
    send_frame(9'h055, 1, 0, 0, 0);
    drive(1'b1, 64);
    wait_drain(500);
    chk("t2_err_cnt", bus.err_cnt, 1);

    // 8N1 with stop bit forced low on 0x81
    set_fmt(0, 8, 0, 0);
    drive(1'b1, 32);
    send_frame(9'h081, 0, 1, 0, 0);
    drive(1'b1, 32);
    wait_drain(200);

    // Break: line low for 20 bit times
    e.data = 9'd0; e.perr = 0; e.ferr = 1; e.brk = 1; e.chk_lat = 0; e.fall = cyc;
    q.push_back(e);
    drive(1'b0, 320);
    chk("brk_busy_low_line", bus.busy, 1);
    drive(1'b1, 10);
    chk("brk_busy_after_high", bus.busy, 0);
    drive(1'b1, 200);
    wait_drain(10);

    // 4-clk glitch on idle line: false start
    drive(1'b0, 4);
    drive(1'b1, 10);
    chk("glitch_busy", bus.busy, 0);
    drive(1'b1, 100);
    chk("glitch_frame_cnt", bus.frame_cnt, 5);

    // Back-to-back 9N1 frames, then en dropped mid third frame
    do_reset();
    set_fmt(0, 9, 0, 0);
    send_frame(9'h1FF, 0, 0, 0, 0);
    send_frame(9'h100, 0, 0, 0, 0);
    drive(1'b0, 16);
    drive(1'b1, 16);
    drive(1'b0, 16);
    bus.en = 1'b0;
    nclk(1);
    chk("en_drop_busy", bus.busy, 0);
    drive(1'b1, 16 * 8);
    wait_drain(10);
    chk("en_drop_frame_cnt", bus.frame_cnt, 2);
    bus.en = 1'b1;
    nclk(5);

    // Randomized formats, data and faults; format scrambled mid-frame
    for (int it = 0; it < 30; it++) begin
      set_fmt($urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 7),
              1'($urandom_range(0, 1)));
      drive(1'b1, 16 * (int'(bus.prescaler) + 1) * $urandom_range(1, 2));
      d = 9'($urandom);
      if ($urandom_range(0, 7) == 0) d = 9'd0;
      send_frame(d, ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0), 1, 0);
      drive(1'b1, 8);
      wait_drain(2000);
    end

    drive(1'b1, 100);
    wait_drain(2000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
    $fatal(1);
  end

endmodule
`default_nettype wire
